lights_out_timer: RTL and testbench

Downstream partner of the starting-line control FSM. When the FSM raises its start-delay request, this block loads a pseudo-random delay from the PRBS, counts it down in milliseconds, and pulses delay-complete back to the FSM. It then turns the lights out and measures the driver's reaction time to the button press. The result is given in binary and in BCD for the seven-segment display. A button press during the delay is flagged as a jump start.

---
 rtl/lights_out_timer.sv | 186 ++++++++++++++++++
 tb/tb_lights_out_timer.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lights_out_timer.sv
// Start-line lights-out timer: random start delay, jump-start detection and
// driver reaction-time measurement with binary and BCD results.
module lights_out_timer #(
    parameter int TICKS_PER_MS = 50000,
    parameter int MIN_DELAY_MS = 200,
    parameter int PRBS_WIDTH   = 16,
    parameter int DELAY_BITS   = 11
) (
    input  logic                  i_clk,
    input  logic                  i_arstN,
    input  logic                  i_startDelay,
    input  logic [PRBS_WIDTH-1:0] i_prbs,
    input  logic                  i_button,
    output logic                  o_delayComplete,
    output logic                  o_lightsOut,
    output logic                  o_jumpStart,
    output logic [13:0]           o_reactionMs,
    output logic [15:0]           o_reactionBcd,
    output logic                  o_valid
);

    localparam int PW = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_MS - 1);
    // The cycle that samples the start rise counts as the first prescaler tick.
    localparam logic [PW-1:0] PRESC_START = (TICKS_PER_MS > 1) ? PW'(1) : '0;
    localparam logic [13:0] MS_SAT = 14'd9999;

    typedef enum logic [1:0] {IDLE, DELAY, MEASURE, CONVERT} state_t;

    state_t state, state_next;

    logic          start_q, button_q;
    logic          start_rise, button_rise;
    logic [PW-1:0] presc;
    logic          wrap;
    logic [11:0]   ms_left;
    logic [11:0]   delay_load;
    logic [13:0]   react_cnt;
    logic [13:0]   bin_sr;
    logic [15:0]   bcd_sr;
    logic [29:0]   dd_next;
    logic [3:0]    iter;
    logic          prbs_unused;

    logic load_run, jump, delay_done, hit, timeout, conv_last;

    function automatic logic [13:0] sat_inc(input logic [13:0] v);
        return (v >= MS_SAT) ? MS_SAT : v + 14'd1;
    endfunction

    function automatic logic [3:0] add3(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

    function automatic logic [29:0] dd_step(input logic [29:0] v);
        logic [29:0] a;
        a        = v;
        a[17:14] = add3(a[17:14]);
        a[21:18] = add3(a[21:18]);
        a[25:22] = add3(a[25:22]);
        a[29:26] = add3(a[29:26]);
        return {a[28:0], 1'b0};
    endfunction

    assign start_rise  = i_startDelay & ~start_q;
    assign button_rise = i_button & ~button_q;
    assign wrap        = (presc == PRESC_LAST);
    assign delay_load  = 12'(MIN_DELAY_MS) + 12'(i_prbs[DELAY_BITS-1:0]);
    assign dd_next     = dd_step({bcd_sr, bin_sr});
    assign prbs_unused = ^i_prbs;

    always_ff @(posedge i_clk or negedge i_arstN) begin
        if (!i_arstN) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (load_run) state_next = DELAY;
            DELAY: begin
                if (!i_startDelay || jump) state_next = IDLE;
                else if (delay_done)       state_next = MEASURE;
            end
            MEASURE: if (hit || timeout) state_next = CONVERT;
            CONVERT: if (conv_last) state_next = IDLE;
        endcase
    end

    // Jump start beats the final wrap; an FSM abort beats both.
    always_comb begin
        load_run   = 1'b0;
        jump       = 1'b0;
        delay_done = 1'b0;
        hit        = 1'b0;
        timeout    = 1'b0;
        conv_last  = 1'b0;
        unique case (state)
            IDLE: load_run = start_rise;
            DELAY: begin
                if (i_startDelay) begin
                    jump       = button_rise;
                    delay_done = !button_rise && wrap && (ms_left <= 12'd1);
                end
            end
            MEASURE: begin
                hit     = button_rise;
                timeout = !button_rise && (react_cnt == MS_SAT);
            end
            CONVERT: conv_last = (iter == 4'd13);
        endcase
    end

    always_ff @(posedge i_clk or negedge i_arstN) begin
        if (!i_arstN) begin
            start_q         <= 1'b0;
            button_q        <= 1'b0;
            presc           <= '0;
            ms_left         <= '0;
            react_cnt       <= '0;
            bin_sr          <= '0;
            bcd_sr          <= '0;
            iter            <= '0;
            o_delayComplete <= 1'b0;
            o_lightsOut     <= 1'b0;
            o_jumpStart     <= 1'b0;
            o_reactionMs    <= '0;
            o_reactionBcd   <= '0;
            o_valid         <= 1'b0;
        end else begin
            start_q         <= i_startDelay;
            button_q        <= i_button;
            o_delayComplete <= jump | delay_done;
            unique case (state)
                IDLE: begin
                    if (load_run) begin
                        ms_left     <= delay_load;
                        presc       <= PRESC_START;
                        o_valid     <= 1'b0;
                        o_jumpStart <= 1'b0;
                    end
                end
                DELAY: begin
                    presc <= wrap ? '0 : presc + 1'b1;
                    if (wrap && ms_left != 12'd0) ms_left <= ms_left - 12'd1;
                    if (jump) begin
                        o_jumpStart  <= 1'b1;
                        o_reactionMs <= '0;
                    end
                    if (delay_done) begin
                        presc     <= '0;
                        react_cnt <= '0;
                    end
                end
                MEASURE: begin
                    // Timing starts from the first cycle the lights are out.
                    if (o_lightsOut) begin
                        presc <= wrap ? '0 : presc + 1'b1;
                        if (wrap) react_cnt <= sat_inc(react_cnt);
                    end
                    if (hit || timeout) begin
                        o_lightsOut  <= 1'b0;
                        o_reactionMs <= react_cnt;
                        bin_sr       <= react_cnt;
                        bcd_sr       <= '0;
                        iter         <= '0;
                    end else begin
                        o_lightsOut <= 1'b1;
                    end
                end
                CONVERT: begin
                    {bcd_sr, bin_sr} <= dd_next;
                    iter             <= iter + 4'd1;
                    if (conv_last) begin
                        o_reactionBcd <= dd_next[29:14];
                        o_valid       <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lights_out_timer.sv
// Randomised bench for lights_out_timer against a timestamp-based reference
// model of the start delay, jump start and reaction measurement.
module tb_lights_out_timer;

    localparam int T      = 4;
    localparam int MIN_MS = 2;
    localparam int DB     = 3;

    localparam int PH_IDLE  = 0;
    localparam int PH_DELAY = 1;
    localparam int PH_MEAS  = 2;
    localparam int PH_CONV  = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] prbs;
    logic        btn;
    logic        delay_complete;
    logic        lights_out;
    logic        jump_start;
    logic [13:0] reaction_ms;
    logic [15:0] reaction_bcd;
    logic        valid;

    lights_out_timer #(
        .TICKS_PER_MS(T),
        .MIN_DELAY_MS(MIN_MS),
        .PRBS_WIDTH(16),
        .DELAY_BITS(DB)
    ) dut (
        .i_clk(clk),
        .i_arstN(rst_n),
        .i_startDelay(start),
        .i_prbs(prbs),
        .i_button(btn),
        .o_delayComplete(delay_complete),
        .o_lightsOut(lights_out),
        .o_jumpStart(jump_start),
        .o_reactionMs(reaction_ms),
        .o_reactionBcd(reaction_bcd),
        .o_valid(valid)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int c0 = 0;

    // reference model: phase plus event timestamps in cycle numbers
    int          m_phase;
    int          t_pulse, t_lr, t_done;
    bit          e_dc, e_lo, e_js, e_valid;
    int          e_ms;
    logic [15:0] e_bcd;
    bit          prev_start, prev_btn;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                     tag, obs, obs, exp, exp, cyc);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic model_reset();
        m_phase    = PH_IDLE;
        t_pulse    = 0;
        t_lr       = 0;
        t_done     = 0;
        e_dc       = 1'b0;
        e_lo       = 1'b0;
        e_js       = 1'b0;
        e_valid    = 1'b0;
        e_ms       = 0;
        e_bcd      = '0;
        prev_start = 1'b0;
        prev_btn   = 1'b0;
    endtask

    // Predict the outputs of cycle cyc+1 from the inputs sampled in cycle cyc.
    task automatic model_step();
        int k, d, ms_val;
        bit srise, brise;
        if (!rst_n) begin
            model_reset();
            return;
        end
        k     = cyc;
        srise = start && !prev_start;
        brise = btn && !prev_btn;
        e_dc  = 1'b0;
        case (m_phase)
            PH_IDLE: begin
                if (srise) begin
                    d       = MIN_MS + (int'(prbs) % (1 << DB));
                    t_pulse = k + d * T;
                    m_phase = PH_DELAY;
                    e_valid = 1'b0;
                    e_js    = 1'b0;
                end
            end
            PH_DELAY: begin
                if (!start) begin
                    m_phase = PH_IDLE;
                end else if (brise) begin
                    e_dc    = 1'b1;
                    e_js    = 1'b1;
                    e_ms    = 0;
                    m_phase = PH_IDLE;
                end else if (k + 1 == t_pulse) begin
                    e_dc    = 1'b1;
                    t_lr    = t_pulse + 1;
                    m_phase = PH_MEAS;
                end
            end
            PH_MEAS: begin
                ms_val = (k < t_lr) ? 0 : (k - t_lr) / T;
                if (brise || ms_val >= 9999) begin
                    e_ms    = (ms_val > 9999) ? 9999 : ms_val;
                    e_lo    = 1'b0;
                    t_done  = k + 15;
                    m_phase = PH_CONV;
                end else begin
                    e_lo = 1'b1;
                end
            end
            default: begin
                if (k + 1 == t_done) begin
                    e_bcd   = to_bcd(e_ms);
                    e_valid = 1'b1;
                    m_phase = PH_IDLE;
                end
            end
        endcase
        prev_start = start;
        prev_btn   = btn;
    endtask

    task automatic check_outputs();
        chk("m_dc",    32'(delay_complete), 32'(e_dc));
        chk("m_lo",    32'(lights_out),     32'(e_lo));
        chk("m_js",    32'(jump_start),     32'(e_js));
        chk("m_valid", 32'(valid),          32'(e_valid));
        chk("m_ms",    32'(reaction_ms),    e_ms);
        chk("m_bcd",   32'(reaction_bcd),   32'(e_bcd));
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        check_outputs();
    endtask

    task automatic start_run(input logic [15:0] p);
        prbs  = p;
        start = 1'b1;
        c0    = cyc;
        tick();
    endtask

    task automatic wait_dc();
        for (int i = 0; i < 2300 * T && !delay_complete; i++) tick();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int lr, s, off, d;
        logic [15:0] p;

        rst_n = 1'b0;
        start = 1'b0;
        btn   = 1'b0;
        prbs  = '0;
        model_reset();
        repeat (3) tick();
        rst_n = 1'b1;
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_ms", 32'(reaction_ms), 32'd0);

        // idle: random button activity must be ignored
        for (int i = 0; i < 24; i++) begin
            btn = 1'($urandom_range(0, 1));
            tick();
        end
        btn = 1'b0;
        tick();
        chk("idle_dc", 32'(delay_complete), 32'd0);
        chk("idle_lo", 32'(lights_out), 32'd0);
        repeat (2) tick();

        // normal run, D = 5
        start_run(16'h0003);
        wait_dc();
        chk("norm_dc_lat", cyc - c0, 20);
        start = 1'b0;
        tick();
        lr = cyc;
        chk("norm_lo_rise", 32'(lights_out), 32'd1);
        while (cyc < lr + 13) tick();
        btn = 1'b1;
        s   = cyc;
        tick();
        btn = 1'b0;
        chk("norm_ms", 32'(reaction_ms), 32'd3);
        chk("norm_lo_fall", 32'(lights_out), 32'd0);
        while (cyc < s + 14) tick();
        chk("norm_valid_early", 32'(valid), 32'd0);
        tick();
        chk("norm_valid", 32'(valid), 32'd1);
        chk("norm_bcd", 32'(reaction_bcd), 32'h0003);
        repeat (3) tick();

        // jump start 7 cycles into the delay
        start_run(16'($urandom));
        while (cyc < c0 + 7) tick();
        btn = 1'b1;
        tick();
        chk("js_dc", 32'(delay_complete), 32'd1);
        chk("js_flag", 32'(jump_start), 32'd1);
        chk("js_valid", 32'(valid), 32'd0);
        chk("js_ms", 32'(reaction_ms), 32'd0);
        start = 1'b0;
        tick();
        btn = 1'b0;
        chk("js_dc_once", 32'(delay_complete), 32'd0);
        repeat (4) tick();
        chk("js_sticky", 32'(jump_start), 32'd1);
        chk("js_lo", 32'(lights_out), 32'd0);

        // button rise coincides with the final prescaler wrap, D = 3
        start_run(16'h0001);
        while (cyc < c0 + 11) tick();
        btn = 1'b1;
        tick();
        chk("sim_dc", 32'(delay_complete), 32'd1);
        chk("sim_js", 32'(jump_start), 32'd1);
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("sim_lo", 32'(lights_out), 32'd0);
        end
        btn = 1'b0;
        repeat (2) tick();

        // randomised runs
        for (int r = 0; r < 9; r++) begin
            p = 16'($urandom);
            d = MIN_MS + (int'(p) % (1 << DB));
            start_run(p);
            if (r % 3 == 0) begin
                off = int'($urandom_range(1, d * T - 1));
                while (cyc < c0 + off) tick();
                btn = 1'b1;
                tick();
                btn = 1'b0;
                chk("rnd_js", 32'(jump_start), 32'd1);
                tick();
                start = 1'b0;
            end else begin
                wait_dc();
                chk("rnd_dc_lat", cyc - c0, d * T);
                start = 1'b0;
                tick();
                lr  = cyc;
                off = int'($urandom_range(0, 40));
                while (cyc < lr + off) tick();
                btn = 1'b1;
                tick();
                btn = 1'b0;
                repeat (14) tick();
                chk("rnd_ms", 32'(reaction_ms), off / T);
                chk("rnd_valid", 32'(valid), 32'd1);
                chk("rnd_bcd", 32'(reaction_bcd), 32'(to_bcd(off / T)));
            end
            repeat (3) tick();
        end

        // timeout with no press
        start_run(16'h0002);
        wait_dc();
        start = 1'b0;
        tick();
        lr = cyc;
        for (int i = 0; i < 9999 * T + 100 && !valid; i++) tick();
        chk("to_cyc", cyc - lr, 9999 * T + 15);
        chk("to_ms", 32'(reaction_ms), 32'd9999);
        chk("to_bcd", 32'(reaction_bcd), 32'h9999);
        chk("to_valid", 32'(valid), 32'd1);
        chk("to_lo", 32'(lights_out), 32'd0);
        repeat (3) tick();

        // asynchronous reset in the middle of a delay
        start_run(16'h0005);
        repeat (10) tick();
        rst_n = 1'b0;
        #1;
        chk("arst_dc", 32'(delay_complete), 32'd0);
        chk("arst_lo", 32'(lights_out), 32'd0);
        chk("arst_js", 32'(jump_start), 32'd0);
        chk("arst_valid", 32'(valid), 32'd0);
        chk("arst_ms", 32'(reaction_ms), 32'd0);
        chk("arst_bcd", 32'(reaction_bcd), 32'd0);
        start = 1'b0;
        btn   = 1'b1;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (4) tick();
        chk("rst_nopulse", 32'(delay_complete), 32'd0);

        // new run reloads from the current PRBS; held button is not a press
        start_run(16'h0006);
        wait_dc();
        chk("rst_dc_lat", cyc - c0, 32);
        chk("held_js", 32'(jump_start), 32'd0);
        start = 1'b0;
        tick();
        lr = cyc;
        chk("held_lo_rise", 32'(lights_out), 32'd1);
        while (cyc < lr + 5) tick();
        chk("held_lo", 32'(lights_out), 32'd1);
        btn = 1'b0;
        while (cyc < lr + 8) tick();
        btn = 1'b1;
        tick();
        btn = 1'b0;
        chk("held_ms", 32'(reaction_ms), 32'd2);
        repeat (14) tick();
        chk("held_valid", 32'(valid), 32'd1);
        chk("held_bcd", 32'(reaction_bcd), 32'h0002);
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
